// File: rtl/pokemon_match_ctrl_pkg.sv
// Shared encodings and 20 Hz timing defaults for the match sequencer.
package pokemon_match_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ROUND_RST  = 3'd1,
    ST_COUNTDOWN  = 3'd2,
    ST_FIGHT      = 3'd3,
    ST_KO         = 3'd4,
    ST_MATCH_OVER = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    WIN_NONE  = 2'b00,
    WIN_CHAR  = 2'b01,
    WIN_SQUIR = 2'b10,
    WIN_DRAW  = 2'b11
  } winner_e;

  localparam int DEF_COUNT_TICKS  = 20;
  localparam int DEF_COUNT_START  = 3;
  localparam int DEF_KO_TICKS     = 40;
  localparam int DEF_RESULT_TICKS = 100;
  localparam int DEF_WINS_NEEDED  = 2;
  localparam int DEF_FLASH_TICKS  = 6;
  localparam int HEALTH_FULL      = 100;

endpackage

// File: rtl/pokemon_match_ctrl_hit_flash_timer.sv
// Per-player hit flash: any health drop (re)loads a countdown; flash is high while it runs.
module hit_flash_timer
  import pokemon_match_ctrl_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int FLASH_TICKS = DEF_FLASH_TICKS
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_health,
  output logic              o_flash
);

  localparam int CW = $clog2(FLASH_TICKS + 1);
  localparam logic [CW-1:0] FLASH_LOAD = CW'(FLASH_TICKS);

  logic [DATA_W-1:0] r_prev_health;
  logic [CW-1:0]     r_cnt;
  logic              w_drop;

  // Unsigned compare: a refill (rise) never counts as a hit.
  assign w_drop  = (i_health < r_prev_health);
  assign o_flash = (r_cnt != '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prev_health <= DATA_W'(HEALTH_FULL);
      r_cnt         <= '0;
    end else begin
      r_prev_health <= i_health;
      if (w_drop)
        r_cnt <= FLASH_LOAD;
      else if (r_cnt != '0)
        r_cnt <= r_cnt - CW'(1);
    end
  end

endmodule

// File: rtl/pokemon_match_ctrl.sv
// Best-of-N match sequencer: countdown -> fight -> KO -> result, plus hit-flash strobes.
module pokemon_match_ctrl
  import pokemon_match_ctrl_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int COUNT_TICKS  = DEF_COUNT_TICKS,
  parameter int COUNT_START  = DEF_COUNT_START,
  parameter int KO_TICKS     = DEF_KO_TICKS,
  parameter int RESULT_TICKS = DEF_RESULT_TICKS,
  parameter int WINS_NEEDED  = DEF_WINS_NEEDED,
  parameter int FLASH_TICKS  = DEF_FLASH_TICKS
) (
  input  logic              clk_20Hz,
  input  logic              reset,
  input  logic              start_btn,
  input  logic              charmander_alive,
  input  logic              squirtle_alive,
  input  logic [DATA_W-1:0] health_char,
  input  logic [DATA_W-1:0] health_squir,
  output logic              round_restart,
  output logic              play_en,
  output logic [2:0]        match_state,
  output logic [1:0]        countdown_digit,
  output logic [1:0]        wins_char,
  output logic [1:0]        wins_squir,
  output logic [1:0]        round_winner,
  output logic [1:0]        match_winner,
  output logic              flash_char,
  output logic              flash_squir
);

  localparam int TW = 16;
  localparam logic [TW-1:0] CNT_LAST    = TW'(COUNT_TICKS - 1);
  localparam logic [TW-1:0] KO_LAST     = TW'(KO_TICKS - 1);
  localparam logic [TW-1:0] RESULT_DONE = TW'(RESULT_TICKS);
  localparam logic [1:0]    DIGIT_START = 2'(COUNT_START);
  localparam logic [1:0]    WINS_MAX    = 2'(WINS_NEEDED);

  state_e        r_state, w_state_nxt;
  logic [TW-1:0] r_tmr, w_tmr_nxt;
  logic [1:0]    r_digit, w_digit_nxt;
  logic [1:0]    r_wins_char, w_wins_char_nxt;
  logic [1:0]    r_wins_squir, w_wins_squir_nxt;
  winner_e       r_round_winner, w_round_winner_nxt;
  winner_e       r_match_winner, w_match_winner_nxt;

  function automatic logic [1:0] sat_inc(input logic [1:0] v);
    return (v == WINS_MAX) ? v : v + 2'd1;
  endfunction

  always_ff @(posedge clk_20Hz) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_tmr          <= '0;
      r_digit        <= '0;
      r_wins_char    <= '0;
      r_wins_squir   <= '0;
      r_round_winner <= WIN_NONE;
      r_match_winner <= WIN_NONE;
    end else begin
      r_state        <= w_state_nxt;
      r_tmr          <= w_tmr_nxt;
      r_digit        <= w_digit_nxt;
      r_wins_char    <= w_wins_char_nxt;
      r_wins_squir   <= w_wins_squir_nxt;
      r_round_winner <= w_round_winner_nxt;
      r_match_winner <= w_match_winner_nxt;
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_tmr_nxt          = r_tmr;
    w_digit_nxt        = r_digit;
    w_wins_char_nxt    = r_wins_char;
    w_wins_squir_nxt   = r_wins_squir;
    w_round_winner_nxt = r_round_winner;
    w_match_winner_nxt = r_match_winner;
    case (r_state)
      ST_IDLE: begin
        if (start_btn) begin
          w_state_nxt      = ST_ROUND_RST;
          w_wins_char_nxt  = '0;
          w_wins_squir_nxt = '0;
        end
      end
      ST_ROUND_RST: begin
        w_state_nxt        = ST_COUNTDOWN;
        w_digit_nxt        = DIGIT_START;
        w_tmr_nxt          = '0;
        w_round_winner_nxt = WIN_NONE;
      end
      ST_COUNTDOWN: begin
        if (r_tmr == CNT_LAST) begin
          w_tmr_nxt   = '0;
          w_digit_nxt = r_digit - 2'd1;
          if (r_digit == 2'd1)
            w_state_nxt = ST_FIGHT;
        end else begin
          w_tmr_nxt = r_tmr + TW'(1);
        end
      end
      ST_FIGHT: begin
        w_tmr_nxt = '0;
        case ({charmander_alive, squirtle_alive})
          2'b10: begin
            w_state_nxt        = ST_KO;
            w_round_winner_nxt = WIN_CHAR;
            w_wins_char_nxt    = sat_inc(r_wins_char);
          end
          2'b01: begin
            w_state_nxt        = ST_KO;
            w_round_winner_nxt = WIN_SQUIR;
            w_wins_squir_nxt   = sat_inc(r_wins_squir);
          end
          // Double KO: nobody scores, round is replayed.
          2'b00: begin
            w_state_nxt        = ST_KO;
            w_round_winner_nxt = WIN_DRAW;
          end
          default: ;
        endcase
      end
      ST_KO: begin
        if (r_tmr == KO_LAST) begin
          w_tmr_nxt = '0;
          if (r_wins_char == WINS_MAX) begin
            w_state_nxt        = ST_MATCH_OVER;
            w_match_winner_nxt = WIN_CHAR;
          end else if (r_wins_squir == WINS_MAX) begin
            w_state_nxt        = ST_MATCH_OVER;
            w_match_winner_nxt = WIN_SQUIR;
          end else begin
            w_state_nxt = ST_ROUND_RST;
          end
        end else begin
          w_tmr_nxt = r_tmr + TW'(1);
        end
      end
      ST_MATCH_OVER: begin
        if (r_tmr != RESULT_DONE)
          w_tmr_nxt = r_tmr + TW'(1);
        else if (start_btn)
          w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign round_restart   = (r_state == ST_ROUND_RST);
  assign play_en         = (r_state == ST_FIGHT);
  assign match_state     = r_state;
  assign countdown_digit = (r_state == ST_COUNTDOWN) ? r_digit : 2'd0;
  assign wins_char       = r_wins_char;
  assign wins_squir      = r_wins_squir;
  assign round_winner    = r_round_winner;
  assign match_winner    = (r_state == ST_MATCH_OVER) ? r_match_winner : WIN_NONE;

  hit_flash_timer #(.DATA_W(DATA_W), .FLASH_TICKS(FLASH_TICKS)) u_flash_char (
    .i_clk    (clk_20Hz),
    .i_rst    (reset),
    .i_health (health_char),
    .o_flash  (flash_char)
  );

  hit_flash_timer #(.DATA_W(DATA_W), .FLASH_TICKS(FLASH_TICKS)) u_flash_squir (
    .i_clk    (clk_20Hz),
    .i_rst    (reset),
    .i_health (health_squir),
    .o_flash  (flash_squir)
  );

endmodule

// File: tb/tb_pokemon_match_ctrl.sv
// Directed bench for pokemon_match_ctrl with an elapsed-time behavioural model checked every cycle.
module tb_pokemon_match_ctrl;

  localparam int CT = 20, CS = 3, KT = 40, RT = 100, WN = 2, FT = 6;

  logic        clk_20Hz = 1'b0;
  logic        reset, start_btn, charmander_alive, squirtle_alive;
  logic [31:0] health_char, health_squir;
  logic        round_restart, play_en, flash_char, flash_squir;
  logic [2:0]  match_state;
  logic [1:0]  countdown_digit, wins_char, wins_squir, round_winner, match_winner;

  always #5 clk_20Hz = ~clk_20Hz;

  pokemon_match_ctrl #(
    .DATA_W(32), .COUNT_TICKS(CT), .COUNT_START(CS), .KO_TICKS(KT),
    .RESULT_TICKS(RT), .WINS_NEEDED(WN), .FLASH_TICKS(FT)
  ) dut (
    .clk_20Hz        (clk_20Hz),
    .reset           (reset),
    .start_btn       (start_btn),
    .charmander_alive(charmander_alive),
    .squirtle_alive  (squirtle_alive),
    .health_char     (health_char),
    .health_squir    (health_squir),
    .round_restart   (round_restart),
    .play_en         (play_en),
    .match_state     (match_state),
    .countdown_digit (countdown_digit),
    .wins_char       (wins_char),
    .wins_squir      (wins_squir),
    .round_winner    (round_winner),
    .match_winner    (match_winner),
    .flash_char      (flash_char),
    .flash_squir     (flash_squir)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Model: phase number plus ticks elapsed in that phase; flash as an absolute end time.
  int          m_phase, m_t, m_wc, m_ws, m_rw, m_mw, m_cyc, m_fend_c, m_fend_s;
  logic [31:0] m_prev_c, m_prev_s;
  bit          m_valid = 1'b0;

  always @(posedge clk_20Hz) begin
    if (reset) begin
      m_valid = 1'b1;
      m_phase = 0; m_t = 0; m_wc = 0; m_ws = 0; m_rw = 0; m_mw = 0;
      m_cyc = 0; m_fend_c = 0; m_fend_s = 0;
      m_prev_c = 100; m_prev_s = 100;
    end else if (m_valid) begin
      m_cyc++;
      if (health_char < m_prev_c)  m_fend_c = m_cyc + FT;
      if (health_squir < m_prev_s) m_fend_s = m_cyc + FT;
      m_prev_c = health_char;
      m_prev_s = health_squir;
      case (m_phase)
        0: if (start_btn) begin m_phase = 1; m_wc = 0; m_ws = 0; end
        1: begin m_phase = 2; m_t = 0; m_rw = 0; end
        2: begin m_t++; if (m_t == CS * CT) m_phase = 3; end
        3: if (!charmander_alive || !squirtle_alive) begin
             m_phase = 4; m_t = 0;
             if (charmander_alive)      begin m_rw = 1; m_wc = (m_wc + 1 > WN) ? WN : m_wc + 1; end
             else if (squirtle_alive)   begin m_rw = 2; m_ws = (m_ws + 1 > WN) ? WN : m_ws + 1; end
             else                       m_rw = 3;
           end
        4: begin
             m_t++;
             if (m_t == KT) begin
               m_t = 0;
               if (m_wc == WN)      begin m_phase = 5; m_mw = 1; end
               else if (m_ws == WN) begin m_phase = 5; m_mw = 2; end
               else                 m_phase = 1;
             end
           end
        5: if (m_t >= RT) begin if (start_btn) m_phase = 0; end else m_t++;
        default: m_phase = 0;
      endcase
    end
  end

  function automatic int pack_out(input int rr, pe, st, dg, wc, ws, rw, mw, fc, fs);
    return (rr << 16) | (pe << 15) | (st << 12) | (dg << 10) | (wc << 8) |
           (ws << 6) | (rw << 4) | (mw << 2) | (fc << 1) | fs;
  endfunction

  always @(negedge clk_20Hz) begin
    if (m_valid) begin
      chk("outputs_vs_model",
          pack_out(int'(round_restart), int'(play_en), int'(match_state), int'(countdown_digit),
                   int'(wins_char), int'(wins_squir), int'(round_winner), int'(match_winner),
                   int'(flash_char), int'(flash_squir)),
          pack_out(int'(m_phase == 1), int'(m_phase == 3), m_phase,
                   (m_phase == 2) ? CS - m_t / CT : 0, m_wc, m_ws, m_rw,
                   (m_phase == 5) ? m_mw : 0, int'(m_cyc < m_fend_c), int'(m_cyc < m_fend_s)));
    end
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk_20Hz);
  endtask

  task automatic pulse_start;
    start_btn = 1'b1;
    wait_neg(1);
    start_btn = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; start_btn = 1'b0; charmander_alive = 1'b1; squirtle_alive = 1'b1;
    health_char = 32'd100; health_squir = 32'd100;
    wait_neg(3);
    chk("reset_state", int'(match_state), 0);
    chk("reset_flash", int'({flash_char, flash_squir}), 0);
    reset = 1'b0;
    wait_neg(2);

    // Hit flash while idle
    health_char = 32'd80;
    wait_neg(1);
    chk("flash_on_drop", int'(flash_char), 1);
    wait_neg(2);
    health_char = 32'd60;
    wait_neg(6);
    chk("flash_extended_t8", int'(flash_char), 1);
    wait_neg(1);
    chk("flash_off_t9", int'(flash_char), 0);
    health_squir = 32'd90;
    wait_neg(6);
    chk("flash_squir_6th", int'(flash_squir), 1);
    wait_neg(1);
    chk("flash_squir_off", int'(flash_squir), 0);
    health_char = 32'd0;
    wait_neg(7);
    health_char = 32'd100;
    wait_neg(1);
    chk("no_flash_on_refill", int'(flash_char), 0);
    health_squir = 32'd100;

    // Round 1: start, countdown, Charmander wins
    pulse_start;
    chk("round_restart_pulse", int'(round_restart), 1);
    wait_neg(1);
    chk("round_restart_one_tick", int'(round_restart), 0);
    chk("digit_3_first", int'(countdown_digit), 3);
    wait_neg(19);
    chk("digit_3_last", int'(countdown_digit), 3);
    wait_neg(1);
    chk("digit_2", int'(countdown_digit), 2);
    wait_neg(20);
    chk("digit_1", int'(countdown_digit), 1);
    wait_neg(19);
    chk("play_en_t60", int'(play_en), 0);
    wait_neg(1);
    chk("play_en_t61", int'(play_en), 1);
    squirtle_alive = 1'b0;
    wait_neg(1);
    chk("ko_state", int'(match_state), 4);
    chk("ko_winner_char", int'(round_winner), 1);
    chk("wins_char_1", int'(wins_char), 1);
    chk("model_wins_char_1", m_wc, 1);
    squirtle_alive = 1'b1;
    wait_neg(39);
    chk("ko_hold_end", int'(match_state), 4);
    wait_neg(1);
    chk("restart_after_ko", int'(round_restart), 1);

    // Round 2: Charmander takes the match
    wait_neg(61);
    chk("fight_round2", int'(match_state), 3);
    health_squir = 32'd40;
    squirtle_alive = 1'b0;
    wait_neg(1);
    chk("wins_char_2", int'(wins_char), 2);
    squirtle_alive = 1'b1;
    health_squir = 32'd100;
    wait_neg(40);
    chk("match_over", int'(match_state), 5);
    chk("match_winner_char", int'(match_winner), 1);
    wait_neg(49);
    pulse_start;
    chk("start_t50_ignored", int'(match_state), 5);
    wait_neg(49);
    pulse_start;
    chk("start_t100_ignored", int'(match_state), 5);
    pulse_start;
    chk("start_t101_idle", int'(match_state), 0);
    chk("match_winner_cleared", int'(match_winner), 0);

    // Match 2: Squirtle wins one, then a double KO
    pulse_start;
    chk("wins_cleared", int'({wins_char, wins_squir}), 0);
    wait_neg(61);
    charmander_alive = 1'b0;
    wait_neg(1);
    chk("winner_squir", int'(round_winner), 2);
    chk("wins_squir_1", int'(wins_squir), 1);
    charmander_alive = 1'b1;
    wait_neg(40);
    wait_neg(61);
    charmander_alive = 1'b0;
    squirtle_alive = 1'b0;
    wait_neg(1);
    chk("draw_winner", int'(round_winner), 3);
    chk("draw_wins_unchanged", int'({wins_char, wins_squir}), 1);
    charmander_alive = 1'b1;
    squirtle_alive = 1'b1;
    wait_neg(40);
    chk("replay_restart", int'(round_restart), 1);

    // Reset mid-countdown
    wait_neg(10);
    reset = 1'b1;
    wait_neg(1);
    chk("reset_mid_countdown", int'(match_state), 0);
    chk("reset_mid_cd_wins", int'({wins_char, wins_squir, countdown_digit}), 0);
    reset = 1'b0;
    wait_neg(1);

    // Reset mid-KO, with a flash running
    pulse_start;
    wait_neg(61);
    squirtle_alive = 1'b0;
    health_char = 32'd50;
    wait_neg(1);
    chk("ko_flash", int'({match_state, flash_char}), 9);
    squirtle_alive = 1'b1;
    wait_neg(5);
    reset = 1'b1;
    wait_neg(1);
    chk("reset_mid_ko_all",
        int'({round_restart, play_en, match_state, countdown_digit, wins_char, wins_squir,
              round_winner, match_winner, flash_char, flash_squir}), 0);
    reset = 1'b0;
    health_char = 32'd100;
    wait_neg(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
